llc_chi_rdata_tx: RTL and testbench

- CHI-H read-data transmitter for the LLC. It accepts one full cacheline from the data-array read path and serialises it into CHI DAT beats of CHI_DATA_WIDTH bits, critical beat first.
- Per-byte ECC/parity is checked on every beat. Failing beats are flagged DERR. Errors are counted in a saturating counter.
- Sits between the data-array read pipe and the CHI-H DAT channel toward the requester.

---
 rtl/llc_chi_rdata_tx.sv | 161 ++++++++++++++++
 tb/tb_llc_chi_rdata_tx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_chi_rdata_tx.sv
// ---------------------------------------------------------------------------
// llc_chi_rdata_tx
//
// CHI-H read-data transmitter for the LLC. Takes one full cacheline from the
// data-array read pipe and sends it as CHI DAT beats of CHI_DATA_WIDTH bits,
// starting at the beat that holds the requested word and wrapping around the
// line. Every beat is checked against its per-byte even parity. A beat that
// fails, or any beat of a poisoned line, is sent with resp DERR. DERR beats
// are counted in a saturating counter.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   line_valid/ready    cacheline handshake from the data-array read pipe
//   line_data           whole line, beat k at [k*CHI_DATA_WIDTH +: CHI_DATA_WIDTH]
//   line_ecc            even parity per byte, beat k at [k*ECC_BIT_WIDTH +: ECC_BIT_WIDTH]
//   line_poison         whole line marked bad upstream
//   line_txn_id         requester TxnID
//   line_addr_offset    byte offset of the requested word (selects first beat)
//   dat_valid/ready     CHI DAT beat handshake toward the requester
//   dat_data            beat data (never corrected)
//   dat_txn_id          TxnID of the line being sent
//   dat_data_id         beat index within the line
//   dat_resp_err        2'b00 OK, 2'b10 DERR
//   dat_last            final beat of the line
//   err_cnt             saturating count of DERR beats handed off
//   busy                a line is held / being sent
// ---------------------------------------------------------------------------
module llc_chi_rdata_tx #(
    parameter int CACHELINE_SIZE   = 64,
    parameter int CHI_DATA_WIDTH   = 64,
    parameter int CHI_TXN_ID_WIDTH = 16,
    parameter int ECC_ENABLE       = 1,
    parameter int ECC_BIT_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH    = 16,
    localparam int NUM_BEATS       = CACHELINE_SIZE * 8 / CHI_DATA_WIDTH,
    localparam int BEAT_W          = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1,
    localparam int OFFSET_WIDTH    = $clog2(CACHELINE_SIZE)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              line_valid,
    output logic                              line_ready,
    input  logic [CACHELINE_SIZE*8-1:0]       line_data,
    input  logic [NUM_BEATS*ECC_BIT_WIDTH-1:0] line_ecc,
    input  logic                              line_poison,
    input  logic [CHI_TXN_ID_WIDTH-1:0]       line_txn_id,
    input  logic [OFFSET_WIDTH-1:0]           line_addr_offset,
    output logic                              dat_valid,
    input  logic                              dat_ready,
    output logic [CHI_DATA_WIDTH-1:0]         dat_data,
    output logic [CHI_TXN_ID_WIDTH-1:0]       dat_txn_id,
    output logic [BEAT_W-1:0]                 dat_data_id,
    output logic [1:0]                        dat_resp_err,
    output logic                              dat_last,
    output logic [ERR_CNT_WIDTH-1:0]          err_cnt,
    output logic                              busy
);

    localparam int BYTES_PER_BEAT = CHI_DATA_WIDTH / 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]                  state_reg;
    logic [CHI_DATA_WIDTH-1:0]   beat_data_reg [NUM_BEATS];
    logic [ECC_BIT_WIDTH-1:0]    beat_ecc_reg  [NUM_BEATS];
    logic                        poison_reg;
    logic [CHI_TXN_ID_WIDTH-1:0] txn_reg;
    logic [BEAT_W-1:0]           start_reg;
    logic [BEAT_W-1:0]           beat_cnt_reg;
    logic [ERR_CNT_WIDTH-1:0]    err_cnt_reg;

    logic                        sending;
    logic                        is_last;
    logic                        accept;
    logic                        dat_hs;
    logic [BEAT_W-1:0]           beat_idx;
    logic [BEAT_W-1:0]           start_next;
    logic [NUM_BEATS-1:0]        beat_bad;
    logic                        cur_err;

    // Low offset bits address bytes inside a beat and do not affect ordering.
    assign start_next = BEAT_W'(line_addr_offset / BYTES_PER_BEAT);

    // Wrap-around beat order: critical beat first, then the rest of the line.
    assign beat_idx = BEAT_W'((32'(start_reg) + 32'(beat_cnt_reg)) % NUM_BEATS);

    assign sending = (state_reg == ST_SEND);
    assign is_last = sending && (beat_cnt_reg == BEAT_W'(NUM_BEATS - 1));
    assign dat_hs  = sending && dat_ready;

    // Ready in the last-beat cycle lets the next line follow without a bubble.
    assign line_ready = !rst && (!sending || (is_last && dat_ready));
    assign accept     = line_valid && line_ready;

    // Capture the line; data storage needs no reset because every output
    // that exposes it is gated by the SEND state.
    for (genvar gi = 0; gi < NUM_BEATS; gi++) begin : g_store
        always_ff @(posedge clk) begin
            if (accept) begin
                beat_data_reg[gi] <= line_data[gi*CHI_DATA_WIDTH +: CHI_DATA_WIDTH];
                beat_ecc_reg[gi]  <= line_ecc[gi*ECC_BIT_WIDTH +: ECC_BIT_WIDTH];
            end
        end
    end

    // Per-beat check: a byte fails when its XOR disagrees with its parity bit.
    for (genvar gi = 0; gi < NUM_BEATS; gi++) begin : g_check
        logic [ECC_BIT_WIDTH-1:0] byte_par;
        for (genvar gb = 0; gb < ECC_BIT_WIDTH; gb++) begin : g_byte
            assign byte_par[gb] = ^beat_data_reg[gi][gb*8 +: 8];
        end
        assign beat_bad[gi] = (byte_par != beat_ecc_reg[gi]) || poison_reg;
    end

    if (ECC_ENABLE != 0) begin : g_ecc_on
        assign cur_err = beat_bad[beat_idx];
    end else begin : g_ecc_off
        assign cur_err = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            poison_reg   <= 1'b0;
            txn_reg      <= '0;
            start_reg    <= '0;
            beat_cnt_reg <= '0;
            err_cnt_reg  <= '0;
        end else begin
            if (accept) begin
                state_reg    <= ST_SEND;
                poison_reg   <= line_poison;
                txn_reg      <= line_txn_id;
                start_reg    <= start_next;
                beat_cnt_reg <= '0;
            end else if (dat_hs) begin
                if (is_last) begin
                    state_reg <= ST_IDLE;
                end else begin
                    beat_cnt_reg <= beat_cnt_reg + 1'b1;
                end
            end
            if (dat_hs && cur_err && (err_cnt_reg != '1)) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
            end
        end
    end

    // Outputs depend only on state registers, so they stay stable while the
    // DAT channel stalls.
    assign dat_valid    = sending;
    assign dat_data     = sending ? beat_data_reg[beat_idx] : '0;
    assign dat_txn_id   = sending ? txn_reg : '0;
    assign dat_data_id  = sending ? beat_idx : '0;
    assign dat_resp_err = (sending && cur_err) ? 2'b10 : 2'b00;
    assign dat_last     = is_last;
    assign err_cnt      = err_cnt_reg;
    assign busy         = sending;

endmodule

// File: tb/tb_llc_chi_rdata_tx.sv
// ---------------------------------------------------------------------------
// tb_llc_chi_rdata_tx
//
// Bench for llc_chi_rdata_tx (64-byte line, 64-bit beats, 4-bit error
// counter so saturation is reachable). Lines are built with random data and
// correct per-byte parity, then optionally corrupted or poisoned. A queue of
// expected beats is derived from the line, offset and error rules; every
// cycle the DUT outputs are compared with the queue head and model state.
// ---------------------------------------------------------------------------
module tb_llc_chi_rdata_tx;

    localparam int LB = 64;
    localparam int W  = 64;
    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          line_valid = 1'b0;
    logic          line_ready;
    logic [511:0]  line_data = '0;
    logic [63:0]   line_ecc = '0;
    logic          line_poison = 1'b0;
    logic [15:0]   line_txn_id = '0;
    logic [5:0]    line_addr_offset = '0;
    logic          dat_valid;
    logic          dat_ready = 1'b0;
    logic [63:0]   dat_data;
    logic [15:0]   dat_txn_id;
    logic [2:0]    dat_data_id;
    logic [1:0]    dat_resp_err;
    logic          dat_last;
    logic [3:0]    err_cnt;
    logic          busy;

    always #5 clk = ~clk;

    llc_chi_rdata_tx #(
        .CACHELINE_SIZE  (LB),
        .CHI_DATA_WIDTH  (W),
        .CHI_TXN_ID_WIDTH(16),
        .ECC_ENABLE      (1),
        .ECC_BIT_WIDTH   (8),
        .ERR_CNT_WIDTH   (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .line_valid      (line_valid),
        .line_ready      (line_ready),
        .line_data       (line_data),
        .line_ecc        (line_ecc),
        .line_poison     (line_poison),
        .line_txn_id     (line_txn_id),
        .line_addr_offset(line_addr_offset),
        .dat_valid       (dat_valid),
        .dat_ready       (dat_ready),
        .dat_data        (dat_data),
        .dat_txn_id      (dat_txn_id),
        .dat_data_id     (dat_data_id),
        .dat_resp_err    (dat_resp_err),
        .dat_last        (dat_last),
        .err_cnt         (err_cnt),
        .busy            (busy)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] d;
        logic [2:0]  id;
        logic [1:0]  resp;
        logic [15:0] txn;
        logic        last;
    } beat_t;

    beat_t q[$];
    int    m_err = 0;

    logic [511:0] ln_data   [2];
    logic [63:0]  ln_ecc    [2];
    logic         ln_poison [2];
    logic [15:0]  ln_txn    [2];
    logic [5:0]   ln_off    [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Random line with correct even parity on every byte.
    task automatic mk_line(input int i, input logic [15:0] txn, input logic [5:0] off,
                           input logic poison);
        for (int k = 0; k < 16; k++) ln_data[i][k*32 +: 32] = $urandom();
        for (int j = 0; j < 64; j++) ln_ecc[i][j] = ^ln_data[i][j*8 +: 8];
        ln_poison[i] = poison;
        ln_txn[i]    = txn;
        ln_off[i]    = off;
    endtask

    // Expected beat sequence for an accepted line.
    task automatic push_line(input int i);
        beat_t b;
        int    start;
        logic  is_bad;
        start = int'(ln_off[i]) / 8;
        for (int n = 0; n < NB; n++) begin
            b.id   = 3'((start + n) % NB);
            b.d    = ln_data[i][int'(b.id)*64 +: 64];
            is_bad = ln_poison[i];
            for (int bb = 0; bb < 8; bb++)
                if ((^b.d[bb*8 +: 8]) != ln_ecc[i][int'(b.id)*8 + bb]) is_bad = 1'b1;
            b.resp = is_bad ? 2'b10 : 2'b00;
            b.txn  = ln_txn[i];
            b.last = (n == NB - 1);
            q.push_back(b);
        end
    endtask

    // Offer nl lines (held valid until taken) and drain all beats.
    // rmode: 0 ready always, 1 pattern 1,0,0, 2 random.
    // rst_after > 0: pulse reset while the beat after that many handshakes is up.
    task automatic run(input int nl, input int rmode, input int rst_after);
        int   li  = 0;
        int   hs  = 0;
        int   cyc = 0;
        logic exp_rdy;
        logic acc;
        logic hsk;
        while (1) begin
            if (li < nl) begin
                line_valid       = 1'b1;
                line_data        = ln_data[li];
                line_ecc         = ln_ecc[li];
                line_poison      = ln_poison[li];
                line_txn_id      = ln_txn[li];
                line_addr_offset = ln_off[li];
            end else begin
                line_valid = 1'b0;
            end
            case (rmode)
                0:       dat_ready = 1'b1;
                1:       dat_ready = (cyc % 3 == 0);
                default: dat_ready = 1'($urandom_range(0, 1));
            endcase
            if (rst_after > 0 && hs == rst_after) begin
                rst = 1'b1;
                #1;
                chk("rst_line_ready", 64'(line_ready), 64'(0));
                @(posedge clk);
                #1 rst = 1'b0;
                q.delete();
                m_err = 0;
                line_valid = 1'b0;
                @(negedge clk);
                #1;
                chk("rst_dat_valid", 64'(dat_valid), 64'(0));
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_err_cnt", 64'(err_cnt), 64'(m_err));
                chk("rst_dat_last", 64'(dat_last), 64'(0));
                return;
            end
            #1;
            exp_rdy = (q.size() == 0) || (q[0].last && dat_ready);
            chk("line_ready", 64'(line_ready), 64'(exp_rdy));
            chk("dat_valid", 64'(dat_valid), 64'(q.size() > 0));
            chk("busy", 64'(busy), 64'(q.size() > 0));
            chk("err_cnt", 64'(err_cnt), 64'(m_err));
            if (q.size() > 0) begin
                chk("dat_data", dat_data, q[0].d);
                chk("dat_data_id", 64'(dat_data_id), 64'(q[0].id));
                chk("dat_resp_err", 64'(dat_resp_err), 64'(q[0].resp));
                chk("dat_txn_id", 64'(dat_txn_id), 64'(q[0].txn));
                chk("dat_last", 64'(dat_last), 64'(q[0].last));
            end
            acc = line_valid && exp_rdy;
            hsk = (q.size() > 0) && dat_ready;
            @(posedge clk);
            if (hsk) begin
                if (q[0].resp == 2'b10 && m_err != 15) m_err++;
                void'(q.pop_front());
                hs++;
            end
            if (acc) begin
                push_line(li);
                li++;
            end
            cyc++;
            @(negedge clk);
            if (li == nl && q.size() == 0) break;
            if (cyc > 400) begin
                total++;
                bad++;
                $error("FAIL timeout observed=%0d_beats_left expected=0", q.size());
                break;
            end
        end
        line_valid = 1'b0;
        dat_ready  = 1'b0;
    endtask

    initial begin
        int pos;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_line_ready", 64'(line_ready), 64'(0));
        chk("reset_dat_valid", 64'(dat_valid), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_reset_line_ready", 64'(line_ready), 64'(1));
        chk("post_reset_dat_data", dat_data, 64'(0));
        chk("post_reset_dat_txn_id", 64'(dat_txn_id), 64'(0));
        chk("post_reset_dat_data_id", 64'(dat_data_id), 64'(0));
        chk("post_reset_dat_resp_err", 64'(dat_resp_err), 64'(0));
        chk("post_reset_dat_last", 64'(dat_last), 64'(0));
        chk("post_reset_err_cnt", 64'(err_cnt), 64'(0));
        chk("post_reset_busy", 64'(busy), 64'(0));
        @(negedge clk);

        // Single line, offset 0
        mk_line(0, 16'h1234, 6'h00, 1'b0);
        run(1, 0, 0);
        $display("step single_line total=%0d bad=%0d", total, bad);

        // Critical word first
        mk_line(0, 16'h0abc, 6'h28, 1'b0);
        run(1, 0, 0);
        $display("step critical_word total=%0d bad=%0d", total, bad);

        // Backpressure 1,0,0
        mk_line(0, 16'h5555, 6'($urandom_range(0, 63)), 1'b0);
        run(1, 1, 0);
        $display("step backpressure total=%0d bad=%0d", total, bad);

        // Single parity error: beat 3, byte 2
        mk_line(0, 16'h0303, 6'($urandom_range(0, 63)), 1'b0);
        pos = 3*64 + 2*8 + $urandom_range(0, 7);
        ln_data[0][pos] = ~ln_data[0][pos];
        run(1, 0, 0);
        chk("err_cnt_after_parity", 64'(err_cnt), 64'(1));
        $display("step parity_error err_cnt=%0d total=%0d bad=%0d", err_cnt, total, bad);

        // Poisoned lines; second one drives the counter into saturation
        mk_line(0, 16'h0bad, 6'h10, 1'b1);
        run(1, 2, 0);
        chk("err_cnt_after_poison", 64'(err_cnt), 64'(9));
        mk_line(0, 16'h0bae, 6'h38, 1'b1);
        run(1, 2, 0);
        chk("err_cnt_saturated", 64'(err_cnt), 64'(15));
        $display("step poison_saturate err_cnt=%0d total=%0d bad=%0d", err_cnt, total, bad);

        // Back-to-back, ready always then random
        mk_line(0, 16'h1111, 6'h08, 1'b0);
        mk_line(1, 16'h2222, 6'h30, 1'b0);
        run(2, 0, 0);
        mk_line(0, 16'h3333, 6'($urandom_range(0, 63)), 1'b0);
        mk_line(1, 16'h4444, 6'($urandom_range(0, 63)), 1'b1);
        run(2, 2, 0);
        $display("step back_to_back total=%0d bad=%0d", total, bad);

        // Random lines with random errors and ready
        for (int it = 0; it < 6; it++) begin
            mk_line(0, 16'($urandom()), 6'($urandom_range(0, 63)), ($urandom_range(0, 5) == 0));
            mk_line(1, 16'($urandom()), 6'($urandom_range(0, 63)), 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                pos = $urandom_range(0, 511);
                ln_data[1][pos] = ~ln_data[1][pos];
            end
            run(1 + (it % 2), 2, 0);
            $display("step random it=%0d total=%0d bad=%0d", it, total, bad);
        end

        // Reset while the 4th beat is presented, then a fresh line
        mk_line(0, 16'h7777, 6'h00, 1'b1);
        run(1, 0, 3);
        mk_line(0, 16'h8888, 6'h18, 1'b0);
        run(1, 0, 0);
        chk("err_cnt_after_reset_line", 64'(err_cnt), 64'(0));
        $display("step reset_mid_line total=%0d bad=%0d", total, bad);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
